// File: rtl/autb_csr_responder.sv
// Single-beat CSR responder: RW bank, sampled RO inputs, and two delay registers that stall the response.
// Latency: response 1 cycle after accept, or 1+data*CYC_PER_x cycles after a nonzero delay write.
// Backpressure: req_ready only in IDLE; the response is held in RESP until rsp_ready.
module autb_csr_responder #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int N_RW       = 16,
    parameter int N_RO       = 16,
    parameter int CYC_PER_US = 1000,
    parameter int CYC_PER_NS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    input  logic [N_RO*DATA_W-1:0]   ro_data,
    output logic [N_RW*DATA_W-1:0]   rw_data,
    output logic                     delay_busy
);
    localparam int PMAX = (CYC_PER_US > CYC_PER_NS) ? CYC_PER_US : CYC_PER_NS;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam logic [PW-1:0] US_RELOAD = PW'(CYC_PER_US - 1);
    localparam logic [PW-1:0] NS_RELOAD = PW'(CYC_PER_NS - 1);

    typedef enum logic [1:0] {IDLE, DLY, RESP} state_t;
    state_t state_q, state_d;

    logic [N_RW*DATA_W-1:0] rw_q;
    logic [DATA_W-1:0]      dly_us_q, dly_ns_q, unit_q, rdata_q, rd_val;
    logic [PW-1:0]          presc_q, reload_q;
    logic                   err_q, accept, hit_rw, hit_ro, hit_us, hit_ns, dec_err, dly_start;
    int                     addr_i;

    assign accept = req_valid && req_ready;

    always_comb begin
        addr_i = int'(req_addr);
        hit_rw = 1'b0;
        hit_ro = 1'b0;
        rd_val = '0;
        for (int k = 0; k < N_RW; k++) begin
            if (addr_i == k) begin
                hit_rw = 1'b1;
                rd_val = rw_q[k*DATA_W +: DATA_W];
            end
        end
        for (int k = 0; k < N_RO; k++) begin
            if (addr_i == 32 + k) begin
                hit_ro = 1'b1;
                rd_val = ro_data[k*DATA_W +: DATA_W];
            end
        end
        hit_us = (addr_i == 62);
        hit_ns = (addr_i == 63);
        if (hit_us) rd_val = dly_us_q;
        if (hit_ns) rd_val = dly_ns_q;
        dec_err   = !(hit_rw || hit_ro || hit_us || hit_ns) || (req_write && hit_ro);
        dly_start = req_write && (hit_us || hit_ns) && (req_wdata != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = dly_start ? DLY : RESP;
            // The last prescaler wrap of the final unit ends the stall.
            DLY:  if (presc_q == '0 && unit_q == DATA_W'(1)) state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = rst_n && (state_q == IDLE);
        rsp_valid  = (state_q == RESP);
        delay_busy = (state_q == DLY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rw_q     <= '0;
            dly_us_q <= '0;
            dly_ns_q <= '0;
            unit_q   <= '0;
            presc_q  <= '0;
            reload_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_q == DLY) begin
                if (presc_q == '0) begin
                    presc_q <= reload_q;
                    unit_q  <= unit_q - DATA_W'(1);
                end else begin
                    presc_q <= presc_q - PW'(1);
                end
            end
            if (accept) begin
                err_q   <= dec_err;
                rdata_q <= (req_write || dec_err) ? '0 : rd_val;
                if (req_write && !dec_err) begin
                    for (int k = 0; k < N_RW; k++) begin
                        if (addr_i == k) rw_q[k*DATA_W +: DATA_W] <= req_wdata;
                    end
                    if (hit_us) begin
                        dly_us_q <= req_wdata;
                        unit_q   <= req_wdata;
                        presc_q  <= US_RELOAD;
                        reload_q <= US_RELOAD;
                    end
                    if (hit_ns) begin
                        dly_ns_q <= req_wdata;
                        unit_q   <= req_wdata;
                        presc_q  <= NS_RELOAD;
                        reload_q <= NS_RELOAD;
                    end
                end
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign rw_data   = rw_q;
endmodule

// File: tb/tb_autb_csr_responder.sv
// Directed bench for autb_csr_responder with a fast 10-cycle microsecond and 8 RO registers.
module tb_autb_csr_responder;
    localparam int DW = 32;

    logic              clk, rst_n;
    logic              req_valid, req_ready, req_write;
    logic [5:0]        req_addr;
    logic [DW-1:0]     req_wdata;
    logic              rsp_valid, rsp_ready, rsp_err, delay_busy;
    logic [DW-1:0]     rsp_rdata;
    logic [8*DW-1:0]   ro_data;
    logic [16*DW-1:0]  rw_data;

    int                ntests, nfail;
    int                last_lat, last_busy;
    logic [DW-1:0]     last_rdata;
    logic              last_err;
    int                acc_cyc [4];

    autb_csr_responder #(
        .ADDR_W(6), .DATA_W(DW), .N_RW(16), .N_RO(8), .CYC_PER_US(10), .CYC_PER_NS(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ro_data(ro_data), .rw_data(rw_data), .delay_busy(delay_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction: wait for accept, count cycles to rsp_valid, optionally hold rsp_ready low.
    task automatic do_req(input logic wr, input logic [5:0] addr, input logic [DW-1:0] wd, input int hold);
        int guard;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 100) begin
            tick();
            guard++;
        end
        tick();
        req_valid = 1'b0;
        last_lat  = 1;
        last_busy = 0;
        while (!rsp_valid && last_lat < 200) begin
            if (delay_busy) last_busy++;
            tick();
            last_lat++;
        end
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, last_rdata);
            chk("hold_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] exp_v;
        int cyc, n;
        ntests = 0;
        nfail = 0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        ro_data = '0;
        ro_data[2*DW +: DW] = 32'h0000_1234;
        repeat (3) tick();
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_busy", {31'b0, delay_busy}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_rw3", rw_data[3*DW +: DW], 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_req_ready", {31'b0, req_ready}, 32'd1);

        // Basic RW write then readback
        do_req(1'b1, 6'd3, 32'hA5A5_0001, 0);
        chk("wr3_err", {31'b0, last_err}, 32'd0);
        chk("wr3_lat", last_lat, 32'd1);
        chk("wr3_rdata", last_rdata, 32'd0);
        chk("rw3_out", rw_data[3*DW +: DW], 32'hA5A5_0001);
        do_req(1'b0, 6'd3, 32'h0, 0);
        chk("rd3_rdata", last_rdata, 32'hA5A5_0001);
        chk("rd3_lat", last_lat, 32'd1);

        // RO read, RO write error, unmapped read error
        do_req(1'b0, 6'd34, 32'h0, 0);
        chk("ro34_rdata", last_rdata, 32'h0000_1234);
        chk("ro34_err", {31'b0, last_err}, 32'd0);
        do_req(1'b1, 6'd34, 32'hDEAD_BEEF, 0);
        chk("wr_ro_err", {31'b0, last_err}, 32'd1);
        chk("wr_ro_rdata", last_rdata, 32'd0);
        do_req(1'b0, 6'd40, 32'h0, 0);
        chk("rd40_err", {31'b0, last_err}, 32'd1);
        chk("rd40_rdata", last_rdata, 32'd0);
        do_req(1'b1, 6'd20, 32'h5555_AAAA, 0);
        chk("wr20_err", {31'b0, last_err}, 32'd1);
        do_req(1'b0, 6'd15, 32'h0, 0);
        chk("rd15_rdata", last_rdata, 32'd0);

        // Delay registers
        do_req(1'b1, 6'd62, 32'd3, 0);
        chk("dus3_lat", last_lat, 32'd31);
        chk("dus3_busy", last_busy, 32'd30);
        chk("dus3_err", {31'b0, last_err}, 32'd0);
        do_req(1'b1, 6'd63, 32'd0, 0);
        chk("dns0_lat", last_lat, 32'd1);
        chk("dns0_busy", last_busy, 32'd0);
        do_req(1'b1, 6'd63, 32'd2, 0);
        chk("dns2_lat", last_lat, 32'd3);
        do_req(1'b0, 6'd62, 32'h0, 0);
        chk("dus_readback", last_rdata, 32'd3);
        do_req(1'b0, 6'd63, 32'h0, 0);
        chk("dns_readback", last_rdata, 32'd2);

        // Stalled response stays stable
        do_req(1'b0, 6'd3, 32'h0, 5);
        chk("stall_rdata", last_rdata, 32'hA5A5_0001);
        tick();
        chk("stall_released", {31'b0, rsp_valid}, 32'd0);

        // Reset in the middle of a delay
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr = 6'd62;
        req_wdata = 32'd5;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        chk("mid_dly_busy", {31'b0, delay_busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("rstdly_busy", {31'b0, delay_busy}, 32'd0);
        chk("rstdly_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rstdly_rw3", rw_data[3*DW +: DW], 32'd0);
        chk("rstdly_ready", {31'b0, req_ready}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rstdly_idle", {31'b0, req_ready}, 32'd1);
        do_req(1'b0, 6'd62, 32'h0, 0);
        chk("rstdly_dus", last_rdata, 32'd0);

        // Back-to-back writes with rsp_ready tied high
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr = 6'd5;
        req_wdata = 32'h1000_0005;
        cyc = 0;
        n = 0;
        while (n < 4 && cyc < 60) begin
            if (req_ready) begin
                acc_cyc[n] = cyc;
                n++;
                tick();
                req_addr = 6'(5 + n);
                req_wdata = 32'h1000_0005 + n;
            end else begin
                tick();
            end
            cyc++;
        end
        req_valid = 1'b0;
        tick();
        rsp_ready = 1'b0;
        chk("b2b_count", n, 32'd4);
        for (int i = 1; i < 4; i++) chk("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 32'd2);
        for (int i = 0; i < 4; i++) begin
            exp_v = 32'h1000_0005 + i;
            chk("b2b_reg", rw_data[(5+i)*DW +: DW], exp_v);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
